// File: rtl/motor_fault_scheduler.sv
// Fault-scenario sequencer for the motor signal generator: walks a table of {mode, cycles}
// entries and drives gen_mode/gen_rst. Define MOTOR_SCHED_LOOP_EN to add the loop input.
module motor_fault_scheduler #(
    parameter int ADDR_W            = 2,
    parameter int CYC_W             = 8,
    parameter int SAMPLES_PER_CYCLE = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [1:0]        cfg_mode,
    input  logic [CYC_W-1:0]  cfg_cycles,
    input  logic [ADDR_W-1:0] cfg_last,
    input  logic              start,
    input  logic              abort,
`ifdef MOTOR_SCHED_LOOP_EN
    input  logic              loop,
`endif
    output logic [1:0]        gen_mode,
    output logic              gen_rst,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] entry_idx,
    output logic [CYC_W-1:0]  cycle_cnt
);

    localparam int NUM_ENTRIES = 2 ** ADDR_W;
    localparam int SMP_W       = (SAMPLES_PER_CYCLE > 1) ? $clog2(SAMPLES_PER_CYCLE) : 1;
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(SAMPLES_PER_CYCLE - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t            state;
    logic [1:0]        tbl_mode   [NUM_ENTRIES];
    logic [CYC_W-1:0]  tbl_cycles [NUM_ENTRIES];
    logic [ADDR_W-1:0] last;
    logic [SMP_W-1:0]  smp_cnt;
    logic              entry_end;
    logic              loop_en;
    logic [ADDR_W-1:0] next_idx;

`ifdef MOTOR_SCHED_LOOP_EN
    assign loop_en = loop;
`else
    assign loop_en = 1'b0;
`endif

    assign next_idx = entry_idx + ADDR_W'(1);

    // An entry ends either as a zero-cycle skip in LOAD or on the final sample of its last cycle.
    always_comb begin
        entry_end = 1'b0;
        case (state)
            LOAD:    entry_end = (tbl_cycles[entry_idx] == '0);
            RUN:     entry_end = (smp_cnt == SMP_LAST) &&
                                 (cycle_cnt == tbl_cycles[entry_idx] - CYC_W'(1));
            default: entry_end = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gen_mode  <= 2'b00;
            gen_rst   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            entry_idx <= '0;
            cycle_cnt <= '0;
            smp_cnt   <= '0;
            last      <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                tbl_mode[i]   <= 2'b00;
                tbl_cycles[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (cfg_we && (state == IDLE || state == DONE)) begin
                tbl_mode[cfg_addr]   <= cfg_mode;
                tbl_cycles[cfg_addr] <= cfg_cycles;
            end

            if (abort) begin
                state     <= IDLE;
                gen_mode  <= 2'b00;
                gen_rst   <= 1'b1;
                busy      <= 1'b0;
                entry_idx <= '0;
                cycle_cnt <= '0;
                smp_cnt   <= '0;
            end else if (entry_end) begin
                gen_rst   <= 1'b1;
                smp_cnt   <= '0;
                cycle_cnt <= '0;
                if (entry_idx != last) begin
                    state     <= LOAD;
                    entry_idx <= next_idx;
                    gen_mode  <= tbl_mode[next_idx];
                end else if (loop_en) begin
                    // Looping back to entry 0 marks each completed pass with a done pulse.
                    state     <= LOAD;
                    entry_idx <= '0;
                    gen_mode  <= tbl_mode[0];
                    done      <= 1'b1;
                end else begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        gen_rst  <= 1'b1;
                        gen_mode <= 2'b00;
                        busy     <= 1'b0;
                        if (start) begin
                            state     <= LOAD;
                            busy      <= 1'b1;
                            entry_idx <= '0;
                            last      <= cfg_last;
                            gen_mode  <= tbl_mode[0];
                            smp_cnt   <= '0;
                            cycle_cnt <= '0;
                        end
                    end
                    LOAD: begin
                        state   <= RUN;
                        gen_rst <= 1'b0;
                    end
                    RUN: begin
                        if (smp_cnt == SMP_LAST) begin
                            smp_cnt   <= '0;
                            cycle_cnt <= cycle_cnt + CYC_W'(1);
                        end else begin
                            smp_cnt <= smp_cnt + SMP_W'(1);
                        end
                    end
                    DONE: begin
                        state     <= IDLE;
                        gen_mode  <= 2'b00;
                        entry_idx <= '0;
                        cycle_cnt <= '0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_motor_fault_scheduler.sv
// Scoreboard bench for motor_fault_scheduler: expected per-cycle outputs are derived from the
// table contents and replayed against every busy/done cycle of the DUT.
module tb_motor_fault_scheduler;
    localparam int ADDR_W = 2;
    localparam int CYC_W  = 8;
    localparam int SPC    = 16;
    localparam int NE     = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_we = 1'b0;
    logic [ADDR_W-1:0] cfg_addr = '0;
    logic [1:0]        cfg_mode = '0;
    logic [CYC_W-1:0]  cfg_cycles = '0;
    logic [ADDR_W-1:0] cfg_last = '0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [1:0]        gen_mode;
    logic              gen_rst, busy, done;
    logic [ADDR_W-1:0] entry_idx;
    logic [CYC_W-1:0]  cycle_cnt;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int mode; int grst; int busy; int done; int idx; int cyc; bit pos;
    } row_t;

    row_t exp_q[$];
    row_t scen_q[$];
    row_t mon_r;
    int   m_mode[NE];
    int   m_cyc[NE];

    always #5 clk = ~clk;

    motor_fault_scheduler #(.ADDR_W(ADDR_W), .CYC_W(CYC_W), .SAMPLES_PER_CYCLE(SPC)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mode(cfg_mode),
        .cfg_cycles(cfg_cycles), .cfg_last(cfg_last), .start(start), .abort(abort),
        .gen_mode(gen_mode), .gen_rst(gen_rst), .busy(busy), .done(done),
        .entry_idx(entry_idx), .cycle_cnt(cycle_cnt)
    );

    // Monitor: every cycle the DUT reports activity must match the next expected row.
    always @(negedge clk) begin
        if (!rst && (busy || done)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output: mode=%0d gen_rst=%0d busy=%0d done=%0d idx=%0d cyc=%0d, nothing expected",
                         gen_mode, gen_rst, busy, done, entry_idx, cycle_cnt);
            end else begin
                mon_r = exp_q.pop_front();
                if ((gen_mode !== 2'(mon_r.mode)) || (gen_rst !== 1'(mon_r.grst)) ||
                    (busy !== 1'(mon_r.busy)) || (done !== 1'(mon_r.done)) ||
                    (mon_r.pos && ((entry_idx !== ADDR_W'(mon_r.idx)) ||
                                   (cycle_cnt !== CYC_W'(mon_r.cyc))))) begin
                    failures++;
                    $display("FAIL cycle_row: got mode=%0d gen_rst=%0d busy=%0d done=%0d idx=%0d cyc=%0d; expected mode=%0d gen_rst=%0d busy=%0d done=%0d idx=%0d cyc=%0d",
                             gen_mode, gen_rst, busy, done, entry_idx, cycle_cnt,
                             mon_r.mode, mon_r.grst, mon_r.busy, mon_r.done, mon_r.idx, mon_r.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: each entry is one LOAD cycle plus cycles*SPC RUN cycles, then one DONE cycle.
    function automatic void build_rows(input int lst);
        scen_q.delete();
        for (int e = 0; e <= lst; e++) begin
            scen_q.push_back('{m_mode[e], 1, 1, 0, e, 0, 1'b1});
            for (int k = 0; k < m_cyc[e] * SPC; k++)
                scen_q.push_back('{m_mode[e], 0, 1, 0, e, k / SPC, 1'b1});
        end
        scen_q.push_back('{m_mode[lst], 1, 0, 1, lst, 0, 1'b0});
    endfunction

    task automatic cfg_write(input int addr, input int mode, input int cyc);
        cfg_we = 1'b1;
        cfg_addr = ADDR_W'(addr);
        cfg_mode = 2'(mode);
        cfg_cycles = CYC_W'(cyc);
        tick();
        cfg_we = 1'b0;
        m_mode[addr] = mode;
        m_cyc[addr] = cyc;
    endtask

    task automatic check_idle(input string name);
        check({name, "_gen_mode"}, int'(gen_mode), 0);
        check({name, "_gen_rst"}, int'(gen_rst), 1);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_done"}, int'(done), 0);
    endtask

    // Counts cycles from the current (first busy) cycle to the done cycle.
    task automatic wait_done(input int budget, input bit wr_busy, output int n);
        n = 1;
        forever begin
            @(negedge clk);
            if (done) break;
            if (n >= budget) begin
                checks++;
                failures++;
                $display("FAIL done_timeout: no done after %0d cycles, required by %0d", n, budget);
                abort = 1'b1;
                tick();
                abort = 1'b0;
                exp_q.delete();
                n = -1;
                break;
            end
            n++;
            @(posedge clk);
            #1;
            cfg_we = wr_busy && (n == 5);
            cfg_addr = '0;
            cfg_mode = 2'b11;
            cfg_cycles = CYC_W'(5);
        end
        cfg_we = 1'b0;
    endtask

    task automatic run_scenario(input int lst, input bit wr_busy);
        int n;
        build_rows(lst);
        foreach (scen_q[i]) exp_q.push_back(scen_q[i]);
        cfg_last = ADDR_W'(lst);
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_last = ADDR_W'($urandom);
        wait_done(scen_q.size() + 20, wr_busy, n);
        check("done_latency", n, scen_q.size());
        tick();
        check_idle("after_done");
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic abort_scenario(input int lst, input int k);
        build_rows(lst);
        for (int i = 0; i < k; i++) exp_q.push_back(scen_q[i]);
        cfg_last = ADDR_W'(lst);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (k - 1) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("abort");
        check("abort_entry_idx", int'(entry_idx), 0);
        check("abort_cycle_cnt", int'(cycle_cnt), 0);
        repeat (3) tick();
        check("abort_queue_drained", exp_q.size(), 0);
    endtask

    task automatic relaunch(input int lst);
        int n;
        build_rows(lst);
        repeat (2) foreach (scen_q[i]) exp_q.push_back(scen_q[i]);
        cfg_last = ADDR_W'(lst);
        start = 1'b1;
        tick();
        wait_done(scen_q.size() + 20, 1'b0, n);
        @(posedge clk);
        tick();
        start = 1'b0;
        check("relaunch_busy", int'(busy), 1);
        wait_done(scen_q.size() + 20, 1'b0, n);
        check("relaunch_latency", n, scen_q.size());
        tick();
        check("relaunch_queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NE; i++) begin
            m_mode[i] = 0;
            m_cyc[i] = 0;
        end
        repeat (3) tick();
        check_idle("reset");
        check("reset_entry_idx", int'(entry_idx), 0);
        check("reset_cycle_cnt", int'(cycle_cnt), 0);
        rst = 1'b0;
        tick();

        // Two populated entries; a write attempted mid-run must not land.
        cfg_write(0, 0, 2);
        cfg_write(1, 1, 1);
        run_scenario(1, 1'b1);
        run_scenario(1, 1'b0);

        // Zero-cycle entry is skipped, then aborts at several points.
        cfg_write(0, 2, 0);
        cfg_write(1, 3, 1);
        run_scenario(1, 1'b0);
        abort_scenario(1, 10);
        abort_scenario(1, 1);
        abort_scenario(1, 18);

        // Abort outranks start in IDLE.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("abort_over_start_busy", int'(busy), 0);
        repeat (2) tick();

        relaunch(1);

        // Maximum cycle count, no counter wrap within the entry.
        cfg_write(0, 1, 255);
        run_scenario(0, 1'b0);

        for (int s = 0; s < 12; s++) begin
            int lst;
            for (int e = 0; e < NE; e++)
                cfg_write(e, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            lst = int'($urandom_range(0, NE - 1));
            if (s % 3 == 2) begin
                build_rows(lst);
                abort_scenario(lst, int'($urandom_range(1, scen_q.size() - 1)));
            end else begin
                run_scenario(lst, 1'b0);
            end
        end

        // Asynchronous reset in the middle of RUN clears outputs and the table.
        cfg_write(0, 1, 2);
        cfg_write(1, 2, 1);
        build_rows(1);
        for (int i = 0; i < 9; i++) exp_q.push_back(scen_q[i]);
        cfg_last = ADDR_W'(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_idle("async_reset");
        check("async_reset_queue_drained", exp_q.size(), 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < NE; i++) begin
            m_mode[i] = 0;
            m_cyc[i] = 0;
        end
        tick();
        run_scenario(3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
